// File: rtl/regfile_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package : dump_pkg
// Brief   : Shared sizes and run-control state encoding for regfile_dump_unit
// Revision: 1.0
// ============================================================================
package dump_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = 5;
   localparam int WORD_W    = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DUMP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_unit_if.sv
`default_nettype none
// ============================================================================
// Interface: regfile_dump_unit_if
// Brief    : CPU run-control, register-file debug read and dump stream bundle
// Revision : 1.0
// ============================================================================
interface regfile_dump_unit_if;
   import dump_pkg::*;

   logic                 start;
   logic [WORD_W-1:0]    nxt_pc;
   logic                 cpu_run;
   logic [REG_IDX_W-1:0] rf_rd_addr;
   logic [WORD_W-1:0]    rf_rd_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [REG_IDX_W-1:0] out_idx;
   logic [WORD_W-1:0]    out_data;
   logic [WORD_W-1:0]    cycles_run;
   logic                 halted;
   logic                 done;

   modport master (
      output start, nxt_pc, rf_rd_data, out_ready,
      input  cpu_run, rf_rd_addr, out_valid, out_idx, out_data, cycles_run, halted, done
   );

   modport slave (
      input  start, nxt_pc, rf_rd_data, out_ready,
      output cpu_run, rf_rd_addr, out_valid, out_idx, out_data, cycles_run, halted, done
   );

endinterface
`default_nettype wire

// File: rtl/regfile_dump_unit_halt_detector.sv
`default_nettype none
// ============================================================================
// Module  : halt_detector
// Brief   : Flags a self-looping program once nxt_pc repeats HALT_REPEAT times
// Revision: 1.0
// ============================================================================
module halt_detector
   import dump_pkg::*;
#(
   parameter int unsigned HALT_REPEAT = 2
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              clear_i,
   input  wire logic              enable_i,
   input  wire logic [WORD_W-1:0] nxt_pc_i,
   output logic                   halt_o
);

   logic [WORD_W-1:0] prev_pc_q;
   logic              hist_q;
   logic [31:0]       rep_q;
   logic [31:0]       rep_d;

   // The first enabled cycle has no history, so it can never count as a repeat.
   always_comb begin
      rep_d = rep_q;
      if (enable_i) begin
         rep_d = (hist_q && (nxt_pc_i == prev_pc_q)) ? rep_q + 32'd1 : 32'd0;
      end
   end

   assign halt_o = enable_i && (rep_d == HALT_REPEAT);

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         prev_pc_q <= '0;
         hist_q    <= 1'b0;
         rep_q     <= '0;
      end else if (enable_i) begin
         prev_pc_q <= nxt_pc_i;
         hist_q    <= 1'b1;
         rep_q     <= rep_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_unit.sv
`default_nettype none
// ============================================================================
// Module  : regfile_dump_unit
// Brief   : Gates the CPU for a bounded run, then streams all registers out
// Revision: 1.0
// ============================================================================
module regfile_dump_unit
   import dump_pkg::*;
#(
   parameter int unsigned CYCLE_LIMIT = 233,
   parameter int unsigned HALT_REPEAT = 2
) (
   input  wire logic          clk,
   input  wire logic          reset,
   regfile_dump_unit_if.slave bus
);

   localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

   state_t               state_q;
   logic                 cpu_run_q;
   logic                 out_valid_q;
   logic                 done_q;
   logic                 halted_q;
   logic [WORD_W-1:0]    cycles_q;
   logic [WORD_W-1:0]    cycles_d;
   logic [REG_IDX_W-1:0] ptr_q;
   logic                 start_ok;
   logic                 in_run;
   logic                 limit_hit;
   logic                 halt_fire;

   assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign in_run    = (state_q == ST_RUN);
   assign cycles_d  = cycles_q + 32'd1;
   assign limit_hit = (cycles_d == CYCLE_LIMIT);

   halt_detector #(
      .HALT_REPEAT (HALT_REPEAT)
   ) u_halt_detector (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (start_ok),
      .enable_i (in_run),
      .nxt_pc_i (bus.nxt_pc),
      .halt_o   (halt_fire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cpu_run_q   <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         halted_q    <= 1'b0;
         cycles_q    <= '0;
         ptr_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_q   <= ST_RUN;
                  cpu_run_q <= 1'b1;
                  done_q    <= 1'b0;
                  halted_q  <= 1'b0;
                  cycles_q  <= '0;
                  ptr_q     <= '0;
               end
            end
            ST_RUN: begin
               // cpu_run falls on the same edge that counts the final cycle.
               cycles_q <= cycles_d;
               if (limit_hit || halt_fire) begin
                  state_q     <= ST_DUMP;
                  cpu_run_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  halted_q    <= halt_fire;
               end
            end
            ST_DUMP: begin
               if (out_valid_q && bus.out_ready) begin
                  if (ptr_q == LAST_IDX) begin
                     state_q     <= ST_DONE;
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                     ptr_q       <= '0;
                  end else begin
                     ptr_q <= ptr_q + 5'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // The CPU is frozen while dumping, so the asynchronous read data is stable.
   assign bus.cpu_run    = cpu_run_q;
   assign bus.rf_rd_addr = ptr_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_idx    = ptr_q;
   assign bus.out_data   = out_valid_q ? bus.rf_rd_data : '0;
   assign bus.cycles_run = cycles_q;
   assign bus.halted     = halted_q;
   assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_dump_unit
// Brief   : Randomized run/dump bench against a sequence-level reference model
// Revision: 1.0
// ============================================================================
module tb_regfile_dump_unit;

   localparam int LIMIT_A = 233;
   localparam int LIMIT_B = 52;
   localparam int HREP    = 2;
   localparam int BUDGET  = 3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        out_ready;
   logic [31:0] nxt_pc;
   logic [31:0] rf_mem [32];
   int          cpu_edges;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   regfile_dump_unit_if bus_a ();
   regfile_dump_unit_if bus_b ();

   assign bus_a.start      = start;
   assign bus_a.nxt_pc     = nxt_pc;
   assign bus_a.out_ready  = out_ready;
   assign bus_a.rf_rd_data = rf_mem[bus_a.rf_rd_addr];
   assign bus_b.start      = start;
   assign bus_b.nxt_pc     = nxt_pc;
   assign bus_b.out_ready  = out_ready;
   assign bus_b.rf_rd_data = rf_mem[bus_b.rf_rd_addr];

   regfile_dump_unit #(.CYCLE_LIMIT(LIMIT_A), .HALT_REPEAT(HREP)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   // Second instance shares every input; it stops no later than the first.
   regfile_dump_unit #(.CYCLE_LIMIT(LIMIT_B), .HALT_REPEAT(HREP)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // Program PC trace as a function of executed CPU cycle k (1-based).
   function automatic logic [31:0] prog_pc(input int mode, input int stuck, input int k);
      case (mode)
         0:       return 32'(4 * k);
         1:       return (k >= stuck) ? 32'h0000_0040 : 32'(32'h1000 + 4 * k);
         default: return 32'(4 * (k / 2));
      endcase
   endfunction

   task automatic model(input int limit, input int mode, input int stuck,
                        output int cyc, output bit hlt);
      int eq = 0;
      cyc = limit;
      hlt = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         if (k > 1 && prog_pc(mode, stuck, k) == prog_pc(mode, stuck, k - 1)) eq++;
         else eq = 0;
         if (eq >= HREP) begin
            cyc = k;
            hlt = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_run(input int mode, input int stuck, input int rdy_mode,
                         input bit poke, input int abort_idx);
      int   exp_a, exp_b;
      bit   hlt_a, hlt_b;
      int   run_cnt = 0, words = 0, dump_cyc = 0, cyc = 0;
      int   last_run = -1, first_valid = -1, acc31 = -100, done_at = -1;
      bit   run_now, rdy;
      logic [3:0] pat = 4'b1001;

      model(LIMIT_A, mode, stuck, exp_a, hlt_a);
      model(LIMIT_B, mode, stuck, exp_b, hlt_b);
      for (int r = 0; r < 32; r++)
         rf_mem[r] = (rdy_mode == 1) ? 32'h1000_0000 + 32'(r) : ((r == 0) ? 32'd0 : $urandom);
      cpu_edges = 0;
      nxt_pc    = prog_pc(mode, stuck, 1);
      out_ready = 1'b1;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("start_cpu_run", 32'(bus_a.cpu_run), 32'd1);
      check_eq("start_cycles",  bus_a.cycles_run, 32'd0);
      check_eq("start_halted",  32'(bus_a.halted), 32'd0);
      check_eq("start_done",    32'(bus_a.done), 32'd0);

      while (!(bus_a.done && bus_b.done) && cyc < BUDGET) begin
         if (bus_a.done && done_at < 0) done_at = cyc;
         nxt_pc = prog_pc(mode, stuck, cpu_edges + 1);
         start  = poke && ((bus_a.cpu_run && cpu_edges == 10) || (bus_a.out_valid && dump_cyc == 3));
         rdy    = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[dump_cyc % 4] : 1'($urandom % 2);
         out_ready = rdy;
         run_now   = bus_a.cpu_run;
         if (run_now) begin
            run_cnt++;
            last_run = cyc;
         end
         if (bus_a.out_valid && first_valid < 0) begin
            first_valid = cyc;
            check_eq("dump_after_run", 32'(cyc), 32'(last_run + 1));
         end
         if (first_valid >= 0 && words < 32) begin
            check_eq("dump_valid",   32'(bus_a.out_valid), 32'd1);
            check_eq("dump_idx",     32'(bus_a.out_idx), 32'(words));
            check_eq("dump_rd_addr", 32'(bus_a.rf_rd_addr), 32'(words));
            check_eq("dump_data",    bus_a.out_data, rf_mem[words % 32]);
            if (abort_idx >= 0 && words == abort_idx) begin
               start = 1'b0;
               reset = 1'b1;
               @(posedge clk); #1;
               reset = 1'b0;
               check_eq("abort_cpu_run", 32'(bus_a.cpu_run), 32'd0);
               check_eq("abort_valid",   32'(bus_a.out_valid), 32'd0);
               check_eq("abort_idx",     32'(bus_a.out_idx), 32'd0);
               check_eq("abort_done",    32'(bus_a.done), 32'd0);
               check_eq("abort_cycles",  bus_a.cycles_run, 32'd0);
               return;
            end
            if (rdy) begin
               words++;
               if (words == 32) acc31 = cyc;
            end
            dump_cyc++;
         end
         @(posedge clk); #1;
         if (run_now) cpu_edges++;
         cyc++;
      end
      start = 1'b0;
      if (bus_a.done && done_at < 0) done_at = cyc;
      check_eq("run_timeout",      32'(cyc < BUDGET), 32'd1);
      check_eq("cpu_run_cycles",   32'(run_cnt), 32'(exp_a));
      check_eq("cycles_run_a",     bus_a.cycles_run, 32'(exp_a));
      check_eq("halted_a",         32'(bus_a.halted), 32'(hlt_a));
      check_eq("words_accepted",   32'(words), 32'd32);
      check_eq("done_after_last",  32'(done_at), 32'(acc31 + 1));
      check_eq("done_valid_low",   32'(bus_a.out_valid), 32'd0);
      check_eq("done_data_zero",   bus_a.out_data, 32'd0);
      check_eq("cycles_run_b",     bus_b.cycles_run, 32'(exp_b));
      check_eq("halted_b",         32'(bus_b.halted), 32'(hlt_b));
      if (rdy_mode == 0) check_eq("dump_span", 32'(done_at - first_valid), 32'd32);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      nxt_pc    = '0;
      cpu_edges = 0;
      for (int r = 0; r < 32; r++) rf_mem[r] = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_eq("rst_cpu_run",  32'(bus_a.cpu_run), 32'd0);
      check_eq("rst_valid",    32'(bus_a.out_valid), 32'd0);
      check_eq("rst_idx",      32'(bus_a.out_idx), 32'd0);
      check_eq("rst_data",     bus_a.out_data, 32'd0);
      check_eq("rst_rd_addr",  32'(bus_a.rf_rd_addr), 32'd0);
      check_eq("rst_cycles",   bus_a.cycles_run, 32'd0);
      check_eq("rst_halted",   32'(bus_a.halted), 32'd0);
      check_eq("rst_done",     32'(bus_a.done), 32'd0);
      @(posedge clk); #1;
      check_eq("idle_no_run",  32'(bus_a.cpu_run), 32'd0);

      do_run(0, 0,  0, 1'b0, -1);   // never loops: full CYCLE_LIMIT
      do_run(1, 50, 0, 1'b0, -1);   // j . from cycle 50: halt after 52
      do_run(1, 50, 1, 1'b0, -1);   // backpressure 1,0,0,1
      do_run(1, 30, 0, 1'b1, -1);   // start pulses during RUN and DUMP
      do_run(1, 5,  0, 1'b0, 10);   // reset mid-dump at idx 10
      do_run(0, 0,  0, 1'b0, -1);   // fresh run after the abort
      do_run(2, 0,  2, 1'b0, -1);   // single repeats only
      do_run(1, 1,  0, 1'b0, -1);   // stuck from the first cycle
      for (int i = 0; i < 6; i++)
         do_run(int'($urandom % 3), int'($urandom_range(1, 260)), 2, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_dump_unit.md
Name: regfile_dump_unit

Overview:
- Run-control and register-dump stage that sits directly downstream of the single-cycle MIPS `cpu`.
- Gates CPU execution for a bounded number of cycles, or until the program self-loops (halt).
- Then freezes the CPU and streams all 32 architectural registers out over a valid/ready port.
- Replaces fixed-delay hierarchical register peeking in benches; also usable as a debug port on hardware.

Parameters:
- CYCLE_LIMIT, 233, maximum CPU cycles executed per run; legal range 1..2^32-1.
- HALT_REPEAT, 2, consecutive cycles with unchanged nxt_pc that declare a halt; legal range >=1.
- NUM_REGS, 32, registers dumped; fixed by ISA.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- nxt_pc  in  32  CPU next-PC (pc+4 / branch target), sampled every RUN cycle.
- cpu_run  out  1  CPU clock-enable; high only in RUN.
- rf_rd_addr  out  5  register-file debug read address (asynchronous read port).
- rf_rd_data  in  32  register-file debug read data, same cycle as rf_rd_addr.
- out_valid  out  1  dump word available.
- out_ready  in  1  consumer accepts dump word.
- out_idx  out  5  register index of the current dump word.
- out_data  out  32  register value of the current dump word.
- cycles_run  out  32  CPU cycles executed in the last/current run.
- halted  out  1  run ended by halt detection, not by CYCLE_LIMIT.
- done  out  1  dump complete.

Behaviour:
- Reset (synchronous, active-high) puts the block in IDLE and zeroes every output: cpu_run, out_valid, out_idx, out_data, rf_rd_addr, cycles_run, halted, done.
- Reset asserted mid-RUN or mid-DUMP aborts immediately; no partial word is left valid.
- States:
  - IDLE: waits; start=1 -> RUN.
  - RUN: cpu_run=1; cycles_run increments each cycle.
  - DUMP: streams registers.
  - DONE: holds results.
- IDLE/DONE -> RUN on start:
  - clears cycles_run, halted, done, the dump pointer and the halt history.
  - cpu_run rises in the cycle after start is sampled.
- RUN exit:
  - When cycles_run reaches CYCLE_LIMIT, or the halt detector fires, the next state is DUMP.
  - cpu_run drops in that same edge, so exactly cycles_run CPU edges were enabled.
  - If both conditions hit in the same cycle, halted=1.
- Halt detection:
  - Compares nxt_pc with the value registered on the previous RUN cycle.
  - A repeat counter increments when they are equal and clears otherwise.
  - Fires when the counter reaches HALT_REPEAT.
  - The first RUN cycle has no history and never counts as a repeat.
- DUMP:
  - ptr starts at 0; rf_rd_addr=ptr, out_idx=ptr, out_data=rf_rd_data (CPU is frozen, so stable); out_valid=1.
  - On out_valid & out_ready, ptr increments.
  - Handshake on ptr=31 -> DONE.
  - idx and data hold unchanged while out_ready=0; no word is skipped or duplicated.
  - One word per cycle when out_ready is held high: the 32-word dump takes exactly 32 cycles.
- DONE:
  - done=1, out_valid=0; cycles_run and halted hold.
  - start -> RUN on the next cycle.
- start is ignored in RUN and DUMP.
- cycles_run is 32-bit; it cannot wrap because CYCLE_LIMIT < 2^32.
- Index 0 is dumped like any other register; the read port is responsible for returning 0.

Decomposition:
- Shared package `dump_pkg`:
  - state enum {IDLE, RUN, DUMP, DONE};
  - NUM_REGS=32, REG_IDX_W=5, WORD_W=32.
- Sub-module `halt_detector`:
  - inputs: clk, reset, clear, enable, nxt_pc;
  - output: halt pulse;
  - contains the previous-PC register and the repeat counter.
- FSM, cycle counter and dump pointer live in the top module.

Test Plan:
- Reset mid-DUMP at ptr=10 -> next cycle IDLE; out_valid=0, out_idx=0, done=0, cpu_run=0; a subsequent start gives a full fresh run.
- CYCLE_LIMIT=233; program never self-loops; start pulse; out_ready=1 ->
  - cpu_run high exactly 233 cycles; cycles_run=233, halted=0;
  - 32 words idx 0..31 on consecutive cycles; done=1 on the cycle after idx 31.
- Program ending in `j .` with nxt_pc stuck at 0x0000_0040 from CPU cycle 50, HALT_REPEAT=2 -> DUMP entered after cycle 52 exactly; halted=1, cycles_run=52.
- Backpressure: out_ready toggles 1,0,0,1 during dump; rf model returns 0x1000_0000+idx ->
  - each idx held while ready=0; out_data=0x1000_0000+idx;
  - total accepted words=32 with no repeats.
- Halt detection and limit in the same cycle (CYCLE_LIMIT=52, same `j .` program) -> halted=1, cycles_run=52.
- start asserted during RUN and during DUMP -> ignored; start in DONE -> counters cleared; cpu_run=1 the next cycle.
